// File: rtl/regfile_rd_arb_pkg.sv
// Shared widths, reset level and response payload for the register-file read arbiter.
package regfile_rd_arb_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ROB_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREQ_MAX = 4;

  localparam logic RST_ACT = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0] val1;
    logic [ROB_W-1:0]  pos1;
    logic [DATA_W-1:0] val2;
    logic [ROB_W-1:0]  pos2;
  } rd_resp_t;

  // Pointer width for a round-robin over n requesters, never below one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_rd_arb_if.sv
// Requester, response and register-file read-port signals of the read arbiter.
interface regfile_rd_arb_if #(
  parameter int unsigned NREQ = 2
) ();
  import regfile_rd_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*REG_W-1:0] req_rs1;
  logic [NREQ*REG_W-1:0] req_rs2;
  logic [NREQ-1:0]       req_grant;
  logic [NREQ-1:0]       resp_valid;
  logic [DATA_W-1:0]     resp_val1;
  logic [ROB_W-1:0]      resp_pos1;
  logic [DATA_W-1:0]     resp_val2;
  logic [ROB_W-1:0]      resp_pos2;
  logic [REG_W-1:0]      rf_rs1;
  logic [REG_W-1:0]      rf_rs2;
  logic [DATA_W-1:0]     rf_val1;
  logic [ROB_W-1:0]      rf_pos1;
  logic [DATA_W-1:0]     rf_val2;
  logic [ROB_W-1:0]      rf_pos2;

  modport slave (
    input  req_valid, req_rs1, req_rs2, rf_val1, rf_pos1, rf_val2, rf_pos2,
    output req_grant, resp_valid, resp_val1, resp_pos1, resp_val2, resp_pos2,
           rf_rs1, rf_rs2
  );

  modport master (
    output req_valid, req_rs1, req_rs2, rf_val1, rf_pos1, rf_val2, rf_pos2,
    input  req_grant, resp_valid, resp_val1, resp_pos1, resp_val2, resp_pos2,
           rf_rs1, rf_rs2
  );

endinterface

// File: rtl/regfile_rd_arb_rr_pick.sv
// Combinational round-robin one-hot picker: first set request at or after ptr, wrapping at N.
module regfile_rd_arb_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [PTR_W-1:0] idx_c,
  output logic             any_c
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] cand;

  // Wrap by compare-and-subtract so non-power-of-two N works.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = SUM_W'(ptr) + SUM_W'(k);
      if (cand >= SUM_W'(N)) cand = cand - SUM_W'(N);
      if (!any_c && req[PTR_W'(cand)]) begin
        any_c                   = 1'b1;
        idx_c                   = PTR_W'(cand);
        grant_c[PTR_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_rd_arb.sv
// Shares the register file's two read ports among NREQ requesters, one round-robin grant per
// cycle, with the read result registered and returned the following cycle.
module regfile_rd_arb
  import regfile_rd_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  regfile_rd_arb_if.slave  bus
);

  localparam int unsigned PTR_W = ptr_w(NREQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  rd_resp_t         resp_q, resp_d;

  logic [NREQ-1:0]  pick_grant_c;
  logic [PTR_W-1:0] pick_idx_c;
  logic             pick_any_c;
  logic             go_c;
  logic             grant_any_c;
  logic [NREQ-1:0]  grant_c;
  logic [REG_W-1:0] rs1_c, rs2_c;

  regfile_rd_arb_rr_pick #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  // Grant qualification and read-port steering; idle ports read x0.
  always_comb begin
    go_c        = rdy && !rollback && (rst != RST_ACT);
    grant_c     = go_c ? pick_grant_c : '0;
    grant_any_c = go_c && pick_any_c;
    rs1_c       = '0;
    rs2_c       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        rs1_c = bus.req_rs1[i*REG_W +: REG_W];
        rs2_c = bus.req_rs2[i*REG_W +: REG_W];
      end
    end
  end

  // Rollback outranks the stall; data registers only load on a grant.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (rollback) begin
      resp_valid_d = '0;
      rr_ptr_d     = '0;
    end else if (rdy) begin
      resp_valid_d = grant_c;
      if (grant_any_c) begin
        resp_d.val1 = bus.rf_val1;
        resp_d.pos1 = bus.rf_pos1;
        resp_d.val2 = bus.rf_val2;
        resp_d.pos2 = bus.rf_pos2;
        rr_ptr_d    = (pick_idx_c == PTR_W'(NREQ - 1)) ? '0 : pick_idx_c + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_q       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign bus.req_grant  = grant_c;
  assign bus.rf_rs1     = rs1_c;
  assign bus.rf_rs2     = rs2_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_val1  = resp_q.val1;
  assign bus.resp_pos1  = resp_q.pos1;
  assign bus.resp_val2  = resp_q.val2;
  assign bus.resp_pos2  = resp_q.pos2;

endmodule
